rank_filter_kxk: RTL

- Parametrised successor to the fixed 9x9 median: streaming KxK rank-order filter on a raster grey stream, K odd, 3..9.
- Runtime-selectable rank: 0 = min, N/2 = median, N-1 = max, where N = K*K.
- Replaces the combinational sort with a pipelined MSB-first radix-select: fixed latency, one pixel per clock.
- Sits after grey conversion and before thresholding/edge blocks in the image pipeline.

---
 rtl/rank_filter_pkg.sv | 29 ++
 rtl/rank_filter_kxk_if.sv | 29 ++
 rtl/rank_filter_kxk_rank_select_stage.sv | 58 +++++
 rtl/rank_filter_kxk.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// Shared constants and helpers for the KxK rank-order filter.
package rank_filter_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned MAX_N   = 81;

  function automatic int unsigned win_n(input int unsigned k);
    return k * k;
  endfunction

  function automatic int unsigned win_h(input int unsigned k);
    return (k - 1) / 2;
  endfunction

  function automatic int unsigned default_rank(input int unsigned k);
    return win_n(k) / 2;
  endfunction

  // Counts set bits among the low n bits of v (n = window size).
  function automatic int unsigned popcount(input logic [MAX_N-1:0] v, input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (i < n) cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rank_filter_kxk_if.sv
// Pixel-in / result-out bundle for rank_filter_kxk.
// out_row/out_col exist only when RANK_FILTER_COORD_EN is defined.
interface rank_filter_kxk_if
  import rank_filter_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RANK_W = 7
);
  logic              pix_valid;
  logic [DATA_W-1:0] pix;
  logic              sof;
  logic [RANK_W-1:0] rank;
  logic              out_valid;
  logic [DATA_W-1:0] out_pix;
`ifdef RANK_FILTER_COORD_EN
  logic [COORD_W-1:0] out_row;
  logic [COORD_W-1:0] out_col;

  modport master (output pix_valid, pix, sof, rank,
                  input  out_valid, out_pix, out_row, out_col);
  modport slave  (input  pix_valid, pix, sof, rank,
                  output out_valid, out_pix, out_row, out_col);
`else
  modport master (output pix_valid, pix, sof, rank,
                  input  out_valid, out_pix);
  modport slave  (input  pix_valid, pix, sof, rank,
                  output out_valid, out_pix);
`endif
endinterface

// File: rtl/rank_filter_kxk_rank_select_stage.sv
// One MSB-first radix-select step: resolves result bit BIT and narrows the candidate set.
module rank_select_stage
  import rank_filter_pkg::*;
#(
  parameter int unsigned N      = 81,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RANK_W = 7,
  parameter int unsigned BIT    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N*DATA_W-1:0] in_win,
  input  logic [N-1:0]        in_mask,
  input  logic [RANK_W-1:0]   in_k,
  input  logic [DATA_W-1:0]   in_res,
  output logic                out_valid,
  output logic [N*DATA_W-1:0] out_win,
  output logic [N-1:0]        out_mask,
  output logic [RANK_W-1:0]   out_k,
  output logic [DATA_W-1:0]   out_res
);
  localparam int unsigned ZW = RANK_W + 1;

  logic [N-1:0]      zero_mask_c;
  logic [N-1:0]      next_mask_c;
  logic [ZW-1:0]     zero_cnt_c;
  logic              take_one_c;
  logic [RANK_W-1:0] next_k_c;
  logic [DATA_W-1:0] next_res_c;

  // If k falls among the zero-bit candidates the result bit is 0, else skip past them.
  always_comb begin
    zero_mask_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      zero_mask_c[i] = in_mask[i] & ~in_win[i*DATA_W + BIT];
    end
    zero_cnt_c  = ZW'(popcount(MAX_N'(zero_mask_c), N));
    take_one_c  = ({1'b0, in_k} >= zero_cnt_c);
    next_mask_c = take_one_c ? (in_mask & ~zero_mask_c) : zero_mask_c;
    next_k_c    = take_one_c ? RANK_W'({1'b0, in_k} - zero_cnt_c) : in_k;
    next_res_c  = in_res;
    next_res_c[BIT] = take_one_c;
  end

  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    out_win  <= in_win;
    out_mask <= next_mask_c;
    out_k    <= next_k_c;
    out_res  <= next_res_c;
  end

endmodule

// File: rtl/rank_filter_kxk.sv
// Streaming KxK rank-order filter (min/median/max or any rank) via pipelined radix select.
// Define RANK_FILTER_COORD_EN to carry window-centre coordinates with each result.
module rank_filter_kxk
  import rank_filter_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = 320,
  parameter int unsigned K           = 9,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RANK_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  rank_filter_kxk_if.slave  bus
);
  localparam int unsigned       N        = win_n(K);
  localparam int unsigned       COL_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [RANK_W-1:0] RANK_MAX = RANK_W'(N - 1);
  localparam logic [RANK_W-1:0] RANK_DEF = RANK_W'(default_rank(K));

  logic [COORD_W-1:0]  col;
  logic [COORD_W-1:0]  row;
  logic [COORD_W-1:0]  cur_col;
  logic [COORD_W-1:0]  cur_row;
  logic [COL_W-1:0]    col_idx;
  logic [RANK_W-1:0]   rank_q;
  logic [K*DATA_W-1:0] column;
  logic [N*DATA_W-1:0] win;
  logic                win_valid;
  logic                s0_valid;
  logic [N*DATA_W-1:0] s0_win;
  logic [RANK_W-1:0]   s0_k;

  // A sof pixel is (0,0) regardless of where the counters were.
  assign cur_col = bus.sof ? '0 : col;
  assign cur_row = bus.sof ? '0 : row;
  assign col_idx = cur_col[COL_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.pix_valid) begin
      if (cur_col == COORD_W'(IMAGE_WIDTH - 1)) begin
        col <= '0;
        row <= (cur_row == '1) ? cur_row : cur_row + COORD_W'(1);
      end else begin
        col <= cur_col + COORD_W'(1);
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            rank_q <= RANK_DEF;
    else if (bus.pix_valid && bus.sof)  rank_q <= (bus.rank > RANK_MAX) ? RANK_MAX : bus.rank;
  end

  // column[j] holds the pixel j rows above the current one, same column.
  assign column[DATA_W-1:0] = bus.pix;

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    logic [DATA_W-1:0] mem [IMAGE_WIDTH];
    assign column[(j+1)*DATA_W +: DATA_W] = mem[col_idx];
    always_ff @(posedge clk) begin
      if (bus.pix_valid) mem[col_idx] <= column[j*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j + 1 < K; j++) begin
          win[(i*K + j)*DATA_W +: DATA_W] <= win[(i*K + j + 1)*DATA_W +: DATA_W];
        end
        win[(i*K + K - 1)*DATA_W +: DATA_W] <= column[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      s0_valid  <= 1'b0;
    end else begin
      win_valid <= bus.pix_valid && (cur_row >= COORD_W'(K - 1)) && (cur_col >= COORD_W'(K - 1));
      s0_valid  <= win_valid;
    end
  end

  always_ff @(posedge clk) begin
    s0_win <= win;
    s0_k   <= rank_q;
  end

  logic                st_valid [DATA_W+1];
  logic [N*DATA_W-1:0] st_win   [DATA_W+1];
  logic [N-1:0]        st_mask  [DATA_W+1];
  logic [RANK_W-1:0]   st_k     [DATA_W+1];
  logic [DATA_W-1:0]   st_res   [DATA_W+1];

  assign st_valid[0] = s0_valid;
  assign st_win[0]   = s0_win;
  assign st_mask[0]  = '1;
  assign st_k[0]     = s0_k;
  assign st_res[0]   = '0;

  for (genvar b = 1; b <= DATA_W; b++) begin : g_sel
    rank_select_stage #(
      .N(N), .DATA_W(DATA_W), .RANK_W(RANK_W), .BIT(DATA_W - b)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (st_valid[b-1]),
      .in_win   (st_win[b-1]),
      .in_mask  (st_mask[b-1]),
      .in_k     (st_k[b-1]),
      .in_res   (st_res[b-1]),
      .out_valid(st_valid[b]),
      .out_win  (st_win[b]),
      .out_mask (st_mask[b]),
      .out_k    (st_k[b]),
      .out_res  (st_res[b])
    );
  end

  logic unused_tail;
  assign unused_tail = ^{st_win[DATA_W], st_mask[DATA_W], st_k[DATA_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pix   <= '0;
    end else begin
      bus.out_valid <= st_valid[DATA_W];
      bus.out_pix   <= st_res[DATA_W];
    end
  end

`ifdef RANK_FILTER_COORD_EN
  localparam int unsigned H = win_h(K);

  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic [COORD_W-1:0] pipe_row [DATA_W+1];
  logic [COORD_W-1:0] pipe_col [DATA_W+1];

  // Centre coordinates ride alongside S0 and each select stage.
  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      win_row <= cur_row - COORD_W'(H);
      win_col <= cur_col - COORD_W'(H);
    end
    pipe_row[0] <= win_row;
    pipe_col[0] <= win_col;
    for (int unsigned b = 1; b <= DATA_W; b++) begin
      pipe_row[b] <= pipe_row[b-1];
      pipe_col[b] <= pipe_col[b-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_row <= '0;
      bus.out_col <= '0;
    end else begin
      bus.out_row <= pipe_row[DATA_W];
      bus.out_col <= pipe_col[DATA_W];
    end
  end
`endif

endmodule
